// File: rtl/bus_sync_pkg.sv
// Shared types and defaults for the toggle-handshake bus synchronizer (tx and rx sides).
package bus_sync_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_t;

    localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/bit_sync.sv
// Reset-to-0 flop chain for a single asynchronous level/toggle; used by both tx and rx sides.
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/bus_sync_tx_hs.sv
// a_clk-side transmitter of the toggle-handshake synchronizer: holds one word, flags it with a
// req toggle, waits for the synchronized ack toggle; a one-entry pending buffer queues the next word.
//   state    | meaning
//   IDLE     | no request outstanding, a_req_tgl equals synchronized ack
//   WAIT_ACK | a_data_hold presented, waiting for ack toggle to match a_req_tgl
module bus_sync_tx_hs
    import bus_sync_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int TIMEOUT_W   = 8,
    parameter bit TIMEOUT_EN  = 1'b1
) (
    input  logic             a_clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] a_data_in,
    input  logic             a_valid,
    output logic             a_ready,
    output logic [WIDTH-1:0] a_data_hold,
    output logic             a_req_tgl,
    input  logic             b_ack_tgl,
    output logic             a_busy,
    output logic             a_done_pls,
    output logic             a_timeout_pls
);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] pend, pend_nxt, hold_nxt;
    logic             pend_vld, pend_vld_nxt;
    logic             ack_sync, ack_match, accept, new_req;

    bit_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk     (a_clk),
        .reset_n (reset_n),
        .d       (b_ack_tgl),
        .q       (ack_sync)
    );

    assign ack_match = (ack_sync == a_req_tgl);
    assign a_ready   = ~pend_vld;
    assign accept    = a_valid & a_ready;
    assign a_busy    = (state == WAIT_ACK);

    always_comb begin
        state_nxt    = state;
        hold_nxt     = a_data_hold;
        pend_nxt     = pend;
        pend_vld_nxt = pend_vld;
        new_req      = 1'b0;
        a_done_pls   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    hold_nxt  = a_data_in;
                    new_req   = 1'b1;
                    state_nxt = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (!ack_match) begin
                    if (accept) begin
                        pend_nxt     = a_data_in;
                        pend_vld_nxt = 1'b1;
                    end
                end else begin
                    a_done_pls = 1'b1;
                    if (pend_vld) begin
                        hold_nxt     = pend;
                        pend_vld_nxt = 1'b0;
                        new_req      = 1'b1;
                    end else if (accept) begin
                        // bypass: next word goes straight to hold without an IDLE cycle
                        hold_nxt = a_data_in;
                        new_req  = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge a_clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            a_data_hold <= '0;
            a_req_tgl   <= 1'b0;
            pend        <= '0;
            pend_vld    <= 1'b0;
        end else begin
            state       <= state_nxt;
            a_data_hold <= hold_nxt;
            a_req_tgl   <= a_req_tgl ^ new_req;
            pend        <= pend_nxt;
            pend_vld    <= pend_vld_nxt;
        end
    end

    generate
        if (TIMEOUT_EN) begin : g_tmo
            localparam logic [TIMEOUT_W-1:0] TMO_PRE = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
            logic [TIMEOUT_W-1:0] tmo_cnt;

            always_ff @(posedge a_clk or negedge reset_n) begin
                if (!reset_n) begin
                    tmo_cnt <= '0;
                end else if (new_req) begin
                    tmo_cnt <= '0;
                end else if (a_busy && (tmo_cnt != '1)) begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end

            // fires in the cycle whose increment lands on all-ones, so only once per request
            assign a_timeout_pls = a_busy && !new_req && (tmo_cnt == TMO_PRE);
        end else begin : g_no_tmo
            assign a_timeout_pls = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_bus_sync_tx_hs.sv
// Self-checking bench for bus_sync_tx_hs: cycle vector table plus directed timeout/reset
// sequences and a randomized receiver model in an independent b_clk domain.
module tb_bus_sync_tx_hs;

    logic       a_clk = 1'b0;
    logic       b_clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] a_data_in = '0;
    logic       a_valid = 1'b0;
    logic       a_ready, a_req_tgl, a_busy, a_done_pls, a_timeout_pls;
    logic [3:0] a_data_hold;
    logic       b_ack_tgl;
    logic       ack_drv = 1'b0;
    logic       use_rx = 1'b0;
    logic       rx_ack, rq1, rq2;
    int         b_half = 7;

    int n_cmp = 0;
    int n_err = 0;

    assign b_ack_tgl = use_rx ? rx_ack : ack_drv;

    bus_sync_tx_hs #(.WIDTH(4), .SYNC_STAGES(2), .TIMEOUT_W(4), .TIMEOUT_EN(1'b1)) dut (
        .a_clk         (a_clk),
        .reset_n       (reset_n),
        .a_data_in     (a_data_in),
        .a_valid       (a_valid),
        .a_ready       (a_ready),
        .a_data_hold   (a_data_hold),
        .a_req_tgl     (a_req_tgl),
        .b_ack_tgl     (b_ack_tgl),
        .a_busy        (a_busy),
        .a_done_pls    (a_done_pls),
        .a_timeout_pls (a_timeout_pls)
    );

    always #5 a_clk = ~a_clk;
    always #(b_half) b_clk = ~b_clk;

    // receiver model: sync req, capture held word, toggle ack
    logic [3:0] rx_q[$];
    always @(posedge b_clk or negedge reset_n) begin
        if (!reset_n) begin
            rq1    <= 1'b0;
            rq2    <= 1'b0;
            rx_ack <= 1'b0;
        end else begin
            rq1 <= a_req_tgl;
            rq2 <= rq1;
            if (use_rx && (rq2 != rx_ack)) begin
                rx_q.push_back(a_data_hold);
                rx_ack <= ~rx_ack;
            end
        end
    end

    // hold must not move across an edge unless the preceding cycle was an ack cycle
    logic       mon_en = 1'b0;
    logic       prev_busy = 1'b0, prev_done = 1'b0;
    logic [3:0] prev_hold = '0;
    int         hold_err = 0;
    always @(negedge a_clk) begin
        if (mon_en) begin
            if (prev_busy && !prev_done && (a_data_hold != prev_hold)) hold_err++;
            prev_busy = a_busy;
            prev_done = a_done_pls;
            prev_hold = a_data_hold;
        end
    end

    // {ready, busy, req, hold[3:0], done, timeout}
    function automatic logic [8:0] outs();
        return {a_ready, a_busy, a_req_tgl, a_data_hold, a_done_pls, a_timeout_pls};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic       valid;
        logic [3:0] data;
        logic       ack;
        logic [8:0] exp;
    } vec_t;

    function automatic vec_t v(input logic vl, input logic [3:0] d, input logic ak,
                               input logic rdy, input logic bsy, input logic rq,
                               input logic [3:0] h, input logic dn);
        vec_t r;
        r.valid = vl;
        r.data  = d;
        r.ack   = ak;
        r.exp   = {rdy, bsy, rq, h, dn, 1'b0};
        return r;
    endfunction

    vec_t vecs[$];
    logic [3:0] exp_q[$];

    initial begin
        int lat, pulses, sent, cyc;
        logic acc;

        // 1: single word A, ack 5 cycles after accept
        vecs.push_back(v(1, 4'hA, 0, 1, 0, 0, 4'h0, 0));
        repeat (4) vecs.push_back(v(0, 4'h0, 0, 1, 1, 1, 4'hA, 0));
        vecs.push_back(v(0, 4'h0, 1, 1, 1, 1, 4'hA, 0));
        vecs.push_back(v(0, 4'h0, 1, 1, 1, 1, 4'hA, 0));
        vecs.push_back(v(0, 4'h0, 1, 1, 1, 1, 4'hA, 1));
        vecs.push_back(v(0, 4'h0, 1, 1, 0, 1, 4'hA, 0));
        // 2: words 3,5 back to back, 5 waits in pending
        vecs.push_back(v(1, 4'h3, 1, 1, 0, 1, 4'hA, 0));
        vecs.push_back(v(1, 4'h5, 1, 1, 1, 0, 4'h3, 0));
        vecs.push_back(v(0, 4'h0, 0, 0, 1, 0, 4'h3, 0));
        vecs.push_back(v(0, 4'h0, 0, 0, 1, 0, 4'h3, 0));
        vecs.push_back(v(0, 4'h0, 0, 0, 1, 0, 4'h3, 1));
        vecs.push_back(v(0, 4'h0, 0, 1, 1, 1, 4'h5, 0));
        vecs.push_back(v(0, 4'h0, 1, 1, 1, 1, 4'h5, 0));
        vecs.push_back(v(0, 4'h0, 1, 1, 1, 1, 4'h5, 0));
        vecs.push_back(v(0, 4'h0, 1, 1, 1, 1, 4'h5, 1));
        vecs.push_back(v(0, 4'h0, 1, 1, 0, 1, 4'h5, 0));
        // 3: accept in the ack cycle with pending empty -> bypass
        vecs.push_back(v(1, 4'h6, 1, 1, 0, 1, 4'h5, 0));
        vecs.push_back(v(0, 4'h0, 0, 1, 1, 0, 4'h6, 0));
        vecs.push_back(v(0, 4'h0, 0, 1, 1, 0, 4'h6, 0));
        vecs.push_back(v(1, 4'h9, 0, 1, 1, 0, 4'h6, 1));
        vecs.push_back(v(0, 4'h0, 1, 1, 1, 1, 4'h9, 0));
        vecs.push_back(v(0, 4'h0, 1, 1, 1, 1, 4'h9, 0));
        vecs.push_back(v(0, 4'h0, 1, 1, 1, 1, 4'h9, 1));
        vecs.push_back(v(0, 4'h0, 1, 1, 0, 1, 4'h9, 0));

        repeat (3) @(negedge a_clk);
        #1 check("reset_state", outs(), {1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0});
        @(negedge a_clk) reset_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge a_clk);
            a_valid   = vecs[i].valid;
            a_data_in = vecs[i].data;
            ack_drv   = vecs[i].ack;
            #1 check($sformatf("vec%0d", i), outs(), vecs[i].exp);
        end

        // 4: no ack; pulse once at cycle 15 of WAIT_ACK, late ack still completes
        @(negedge a_clk);
        a_valid = 1'b1;
        a_data_in = 4'hC;
        @(negedge a_clk) a_valid = 1'b0;
        pulses = 0;
        for (int k = 1; k <= 20; k++) begin
            #1;
            if (a_timeout_pls) pulses++;
            if (k == 15) check("timeout_at_15", a_timeout_pls, 1'b1);
            @(negedge a_clk);
        end
        check("timeout_count", pulses, 1);
        check("hold_during_timeout", a_data_hold, 4'hC);
        ack_drv = 1'b0;
        lat = -1;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (a_done_pls) begin
                lat = c;
                break;
            end
            @(negedge a_clk);
        end
        check("late_ack_done_latency", lat, 2);
        @(negedge a_clk);
        #1 check("idle_after_timeout", outs(), {1'b1, 1'b0, 1'b0, 4'hC, 1'b0, 1'b0});

        // 5: async reset while WAIT_ACK with pending full
        @(negedge a_clk);
        a_valid = 1'b1;
        a_data_in = 4'h1;
        @(negedge a_clk) a_data_in = 4'h2;
        @(negedge a_clk) a_valid = 1'b0;
        #1 check("pending_full", outs(), {1'b0, 1'b1, 1'b1, 4'h1, 1'b0, 1'b0});
        #2 reset_n = 1'b0;
        ack_drv = 1'b0;
        #1 check("async_reset", outs(), {1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0});
        #2 reset_n = 1'b1;
        @(negedge a_clk);
        a_valid = 1'b1;
        a_data_in = 4'h7;
        #1 check("post_reset_pre", outs(), {1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0});
        @(negedge a_clk) a_valid = 1'b0;
        #1 check("post_reset_word", outs(), {1'b1, 1'b1, 1'b1, 4'h7, 1'b0, 1'b0});
        ack_drv = 1'b1;
        repeat (4) @(negedge a_clk);
        #1 check("post_reset_idle", outs(), {1'b1, 1'b0, 1'b1, 4'h7, 1'b0, 1'b0});

        // 6: random traffic against the b_clk receiver model
        @(negedge a_clk);
        reset_n = 1'b0;
        ack_drv = 1'b0;
        #2 reset_n = 1'b1;
        use_rx = 1'b1;
        mon_en = 1'b1;
        sent = 0;
        cyc = 0;
        while (sent < 40 && cyc < 4000) begin
            if (cyc % 200 == 0) b_half = $urandom_range(2, 13);
            @(negedge a_clk);
            a_valid = ($urandom_range(0, 2) != 0);
            a_data_in = 4'($urandom_range(0, 15));
            #1 acc = a_ready;
            @(posedge a_clk);
            if (acc && a_valid) begin
                exp_q.push_back(a_data_in);
                sent++;
            end
            cyc++;
        end
        @(negedge a_clk) a_valid = 1'b0;
        check("random_all_sent", sent, 40);
        cyc = 0;
        while (rx_q.size() < exp_q.size() && cyc < 3000) begin
            @(negedge a_clk);
            cyc++;
        end
        repeat (40) @(negedge a_clk);
        check("random_rx_count", rx_q.size(), exp_q.size());
        foreach (exp_q[i]) begin
            if (i < rx_q.size()) check($sformatf("rx_word%0d", i), rx_q[i], exp_q[i]);
        end
        #1 check("random_idle", a_busy, 1'b0);
        check("hold_stable", hold_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
